// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper and the harness that owns start/abort, the expected
// table and the device-under-test output.
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [7:0] exp_table;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       c_out;
  logic [2:0] pattern_idx;
  logic [7:0] table_out;
  logic       busy;
  logic       done;
  logic       pass;

  modport master (
    output start, abort, exp_table, y_in,
    input  a_out, b_out, c_out, pattern_idx, table_out, busy, done, pass
  );

  modport slave (
    input  start, abort, exp_table, y_in,
    output a_out, b_out, c_out, pattern_idx, table_out, busy, done, pass
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives all 8 {a,b,c} patterns with a programmable dwell, captures y on the last
// dwell cycle of each pattern and compares the captured table to exp_table.
module truth_table_sweeper #(
  parameter int DWELL_CYCLES = 10,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  truth_table_sweeper_if.slave   bus,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       table_q;
  logic [7:0]       table_cap;
  logic             pass_q;
  logic             sample;

  // Handshake: start is a level request accepted only in IDLE/DONE; done and pass
  // stay valid (and sticky) until the next accepted start, abort never touches them
  // outside DRIVE.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    sample              = 1'b0;
    table_cap           = table_q;
    table_cap[idx_q]    = bus.y_in;
    case (state_q)
      IDLE:  if (bus.start) state_d = DRIVE;
      DRIVE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          sample = 1'b1;
          if (idx_q == 3'd7) state_d = DONE;
        end
      end
      DONE:  if (bus.start) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      table_q <= 8'h00;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            table_q <= 8'h00;
            pass_q  <= 1'b0;
          end
        end
        DRIVE: begin
          if (bus.abort) begin
            // Partially captured bits are kept for post-mortem inspection.
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            pass_q <= 1'b0;
          end else if (sample) begin
            cnt_q   <= '0;
            table_q <= table_cap;
            if (idx_q == 3'd7) pass_q <= (table_cap == bus.exp_table);
            else               idx_q  <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Pattern index is itself a register, so the pattern pins are registered too;
  // it stays at 7 in DONE, which holds the outputs at 3'b111.
  assign bus.a_out       = idx_q[2];
  assign bus.b_out       = idx_q[1];
  assign bus.c_out       = idx_q[0];
  assign bus.pattern_idx = idx_q;
  assign bus.table_out   = table_q;
  assign bus.busy        = (state_q == DRIVE);
  assign bus.done        = (state_q == DONE);
  assign bus.pass        = pass_q;
  assign state_dbg       = state_q;

endmodule
